// File: rtl/load_access_unit.sv
// Multicycle load path: issues a memory read, waits a fixed latency, then
// extracts and sign/zero-extends a byte, halfword or word with a done pulse.
module load_access_unit #(
  parameter int MEM_LATENCY = 1,
  parameter int DATA_W      = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [1:0]        load_size_control,
  input  logic              load_unsigned,
  input  logic [DATA_W-1:0] address,
  input  logic [DATA_W-1:0] mem_data_in,
  output logic [DATA_W-1:0] mem_address,
  output logic              mem_read,
  output logic              busy,
  output logic              done,
  output logic              misaligned_error,
  output logic [DATA_W-1:0] load_size_out
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_CAPTURE, S_DONE, S_ERR
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(MEM_LATENCY - 1);

  state_t            state_reg, state_next;
  logic [3:0]        counter_reg, counter_next;
  logic [1:0]        size_reg, size_next;
  logic              uns_reg, uns_next;
  logic [DATA_W-1:0] mdr_reg, mdr_next;
  logic [DATA_W-1:0] mem_address_reg, mem_address_next;
  logic              mem_read_reg, mem_read_next;
  logic              done_reg, done_next;
  logic              err_reg, err_next;
  logic [DATA_W-1:0] result_reg, result_next;
  logic              bad_request;
  logic [DATA_W-1:0] extended;

  assign bad_request = (load_size_control == 2'b11) ||
                       (load_size_control == 2'b01 && address[0]) ||
                       (load_size_control == 2'b10 && address[1:0] != 2'b00);

  // Lane is always the low bits of the word, mirroring the store merge.
  always_comb begin
    case (size_reg)
      2'b00:   extended = {{24{mdr_reg[7] & ~uns_reg}}, mdr_reg[7:0]};
      2'b01:   extended = {{16{mdr_reg[15] & ~uns_reg}}, mdr_reg[15:0]};
      default: extended = mdr_reg;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg       <= S_IDLE;
      counter_reg     <= 4'd0;
      size_reg        <= 2'b00;
      uns_reg         <= 1'b0;
      mdr_reg         <= '0;
      mem_address_reg <= '0;
      mem_read_reg    <= 1'b0;
      done_reg        <= 1'b0;
      err_reg         <= 1'b0;
      result_reg      <= '0;
    end else begin
      state_reg       <= state_next;
      counter_reg     <= counter_next;
      size_reg        <= size_next;
      uns_reg         <= uns_next;
      mdr_reg         <= mdr_next;
      mem_address_reg <= mem_address_next;
      mem_read_reg    <= mem_read_next;
      done_reg        <= done_next;
      err_reg         <= err_next;
      result_reg      <= result_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:    if (start) state_next = bad_request ? S_ERR : S_WAIT;
      S_WAIT:    if (counter_reg == 4'd0) state_next = S_CAPTURE;
      S_CAPTURE: state_next = S_DONE;
      S_DONE:    state_next = S_IDLE;
      S_ERR:     state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  // Registered outputs: each state's action lands on the edge that leaves it.
  always_comb begin
    counter_next     = counter_reg;
    size_next        = size_reg;
    uns_next         = uns_reg;
    mdr_next         = mdr_reg;
    mem_address_next = mem_address_reg;
    mem_read_next    = 1'b0;
    done_next        = 1'b0;
    err_next         = 1'b0;
    result_next      = result_reg;
    case (state_reg)
      S_IDLE: begin
        if (start && !bad_request) begin
          size_next        = load_size_control;
          uns_next         = load_unsigned;
          mem_address_next = address;
          counter_next     = CNT_INIT;
          mem_read_next    = 1'b1;
        end
      end
      S_WAIT: begin
        mem_read_next = 1'b1;
        if (counter_reg == 4'd0) mdr_next = mem_data_in;
        else                     counter_next = counter_reg - 4'd1;
      end
      S_CAPTURE: result_next = extended;
      S_DONE:    done_next = 1'b1;
      S_ERR: begin
        done_next = 1'b1;
        err_next  = 1'b1;
      end
      default: ;
    endcase
  end

  assign mem_address      = mem_address_reg;
  assign mem_read         = mem_read_reg;
  assign busy             = (state_reg != S_IDLE);
  assign done             = done_reg;
  assign misaligned_error = err_reg;
  assign load_size_out    = result_reg;

endmodule

// File: tb/tb_load_access_unit.sv
// Directed bench for load_access_unit: one instance with MEM_LATENCY=1 and
// one with MEM_LATENCY=4, sharing clock and reset.
module tb_load_access_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start_v   [2];
  logic [1:0]  size_v    [2];
  logic        uns_v     [2];
  logic [31:0] addr_v    [2];
  logic [31:0] mdata_v   [2];
  logic [31:0] maddr_v   [2];
  logic        mread_v   [2];
  logic        busy_v    [2];
  logic        done_v    [2];
  logic        err_v     [2];
  logic [31:0] res_v     [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  load_access_unit #(.MEM_LATENCY(1), .DATA_W(32)) u_lat1 (
    .clk(clk), .reset_n(reset_n), .start(start_v[0]),
    .load_size_control(size_v[0]), .load_unsigned(uns_v[0]),
    .address(addr_v[0]), .mem_data_in(mdata_v[0]),
    .mem_address(maddr_v[0]), .mem_read(mread_v[0]), .busy(busy_v[0]),
    .done(done_v[0]), .misaligned_error(err_v[0]), .load_size_out(res_v[0])
  );

  load_access_unit #(.MEM_LATENCY(4), .DATA_W(32)) u_lat4 (
    .clk(clk), .reset_n(reset_n), .start(start_v[1]),
    .load_size_control(size_v[1]), .load_unsigned(uns_v[1]),
    .address(addr_v[1]), .mem_data_in(mdata_v[1]),
    .mem_address(maddr_v[1]), .mem_read(mread_v[1]), .busy(busy_v[1]),
    .done(done_v[1]), .misaligned_error(err_v[1]), .load_size_out(res_v[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input int u, input string tag);
    check({tag, "_maddr"}, maddr_v[u], 32'h0);
    check({tag, "_ctl"}, {28'h0, mread_v[u], busy_v[u], done_v[u], err_v[u]}, 32'h0);
    check({tag, "_res"}, res_v[u], 32'h0);
  endtask

  // Issues one request and follows it to its done pulse, checking latency,
  // read-strobe length, address stability and the result.
  task automatic run_load(input int u, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] word,
                          input logic [31:0] exp_res, input logic exp_err,
                          input string tag);
    int lat = (u == 0) ? 1 : 4;
    int rd = 0;
    int bad_addr = 0;
    int edge_done = -1;
    start_v[u] = 1'b1; size_v[u] = sz; uns_v[u] = uns; addr_v[u] = addr;
    mdata_v[u] = (u == 1) ? 32'hA5A5_A5A5 : word;
    tick();
    start_v[u] = 1'b0; size_v[u] = 2'b11; uns_v[u] = ~uns; addr_v[u] = 32'hFFFF_FFFF;
    for (int k = 0; k < 30; k++) begin
      if (mread_v[u]) begin
        rd++;
        if (maddr_v[u] !== addr) bad_addr++;
      end
      if (done_v[u]) begin
        edge_done = k;
        break;
      end
      if (u == 1) mdata_v[u] = (k == lat - 1) ? word : 32'hA5A5_A5A5;
      tick();
    end
    check({tag, "_lat"}, edge_done, exp_err ? 32'd1 : 32'(lat + 2));
    check({tag, "_res"}, res_v[u], exp_res);
    check({tag, "_err"}, {31'h0, err_v[u]}, {31'h0, exp_err});
    check({tag, "_rd"}, rd, exp_err ? 32'd0 : 32'(lat + 1));
    check({tag, "_addr"}, bad_addr, 32'd0);
    check({tag, "_busy"}, {31'h0, busy_v[u]}, 32'h0);
    $display("txn %s size=%b uns=%0d addr=%h res=%h err=%0d done_edge=%0d",
             tag, sz, uns, addr, res_v[u], err_v[u], edge_done);
    tick();
  endtask

  initial begin
    int cnt;
    for (int u = 0; u < 2; u++) begin
      start_v[u] = 1'b0; size_v[u] = 2'b00; uns_v[u] = 1'b0;
      addr_v[u] = 32'h0; mdata_v[u] = 32'h0;
    end
    tick(); tick();
    check_all_zero(0, "rst_u1");
    check_all_zero(1, "rst_u4");
    reset_n = 1'b1;
    tick();
    check_all_zero(0, "idle_u1");

    run_load(0, 2'b00, 1'b0, 32'h100, 32'h1234_5680, 32'hFFFF_FF80, 1'b0, "lb");
    run_load(0, 2'b00, 1'b1, 32'h100, 32'h1234_5680, 32'h0000_0080, 1'b0, "lbu");
    run_load(0, 2'b01, 1'b0, 32'h102, 32'h0000_F00D, 32'hFFFF_F00D, 1'b0, "lh");
    run_load(0, 2'b01, 1'b1, 32'h102, 32'h0000_F00D, 32'h0000_F00D, 1'b0, "lhu");
    run_load(0, 2'b10, 1'b0, 32'h102, 32'h1111_1111, 32'h0000_F00D, 1'b1, "lw_mis");
    run_load(0, 2'b01, 1'b0, 32'h101, 32'h1111_1111, 32'h0000_F00D, 1'b1, "lh_mis");
    run_load(0, 2'b11, 1'b0, 32'h100, 32'h1111_1111, 32'h0000_F00D, 1'b1, "rsvd");
    run_load(0, 2'b10, 1'b1, 32'h104, 32'h8765_4321, 32'h8765_4321, 1'b0, "lw");
    run_load(1, 2'b10, 1'b0, 32'h200, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, "lw_lat4");

    // Extra starts during WAIT and during DONE must both be dropped.
    start_v[0] = 1'b1; size_v[0] = 2'b00; uns_v[0] = 1'b0;
    addr_v[0] = 32'h100; mdata_v[0] = 32'h0000_00FF;
    tick();
    addr_v[0] = 32'h200;
    cnt = 0;
    for (int k = 1; k < 13; k++) begin
      start_v[0] = (k == 1 || k == 3);
      tick();
      if (done_v[0]) cnt++;
    end
    start_v[0] = 1'b0;
    check("busy_dones", cnt, 32'd1);
    check("busy_res", res_v[0], 32'hFFFF_FFFF);
    check("busy_maddr", maddr_v[0], 32'h100);
    $display("txn busy_ignore dones=%0d res=%h", cnt, res_v[0]);

    // Reset in the middle of a read.
    start_v[0] = 1'b1; size_v[0] = 2'b00; uns_v[0] = 1'b0;
    addr_v[0] = 32'h300; mdata_v[0] = 32'h0000_007F;
    tick();
    start_v[0] = 1'b0;
    check("mid_mread", {31'h0, mread_v[0]}, 32'h1);
    #1 reset_n = 1'b0;
    #1 check_all_zero(0, "mid_rst");
    tick();
    reset_n = 1'b1;
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (done_v[0]) cnt++;
    end
    check("mid_nodone", cnt, 32'd0);
    $display("txn reset_mid_read dones=%0d", cnt);
    run_load(0, 2'b00, 1'b0, 32'h300, 32'h0000_007F, 32'h0000_007F, 1'b0, "lb_after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
